// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: picks the highest-priority enabled line, saves/restores the PC and vectors the core.
// Optional handler watchdog is enabled by defining IRQ_SEQ_TIMEOUT_EN.
module irq_sequencer #(
  parameter int NIRQ           = 32,
  parameter int VECTORED       = 1,
  parameter int VEC_SHIFT      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_pending,
  input  logic [NIRQ-1:0] irq_mask,
  input  logic            glob_en,
  input  logic            insn_boundary,
  input  logic            retirq,
  input  logic [31:0]     pc,
  input  logic [31:0]     pc_irq,
  output logic            savepc,
  output logic            pc_load,
  output logic [31:0]     pc_next,
  output logic [NIRQ-1:0] irq_ack,
  output logic [4:0]      irq_id,
  output logic            irq_active,
  output logic            timeout
);

  if (NIRQ < 1 || NIRQ > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("irq_sequencer: NIRQ must be 1..32 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_LOAD,
    S_ACTIVE,
    S_RESTORE
  } state_t;

  state_t          state;
  logic [31:0]     ret_pc;
  logic [NIRQ-1:0] req;
  logic            req_any;
  logic [4:0]      sel;
  logic [NIRQ-1:0] ack_vec;
  logic [31:0]     vec_addr;

  // NOTE: every signal written in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    req     = irq_pending & irq_mask;
    req_any = |req;
    sel     = '0;
    // Scan downwards so the lowest set bit is the one that sticks.
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) sel = i[4:0];
    end
  end

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NIRQ; i++) begin
      ack_vec[i] = (irq_id == i[4:0]);
    end
  end

  always_comb begin
    vec_addr = pc_irq;
    if (VECTORED != 0) vec_addr = pc_irq + ({27'b0, irq_id} << VEC_SHIFT);
  end

`ifdef IRQ_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ret_pc     <= '0;
      savepc     <= 1'b0;
      pc_load    <= 1'b0;
      pc_next    <= '0;
      irq_ack    <= '0;
      irq_id     <= '0;
      irq_active <= 1'b0;
`ifdef IRQ_SEQ_TIMEOUT_EN
      wd_cnt     <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; the state arms them for exactly one cycle.
      savepc  <= 1'b0;
      pc_load <= 1'b0;
      pc_next <= '0;
      irq_ack <= '0;
`ifdef IRQ_SEQ_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (glob_en && req_any && insn_boundary) begin
            state  <= S_SAVE;
            irq_id <= sel;
            ret_pc <= pc;
            savepc <= 1'b1;
          end
        end
        S_SAVE: begin
          // The id captured in IDLE proceeds even if the request has gone away.
          state   <= S_LOAD;
          pc_load <= 1'b1;
          pc_next <= vec_addr;
          irq_ack <= ack_vec;
        end
        S_LOAD: begin
          state      <= S_ACTIVE;
          irq_active <= 1'b1;
`ifdef IRQ_SEQ_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
        end
        S_ACTIVE: begin
          if (retirq) begin
            state      <= S_RESTORE;
            irq_active <= 1'b0;
            pc_load    <= 1'b1;
            pc_next    <= ret_pc;
`ifdef IRQ_SEQ_TIMEOUT_EN
          end else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            state      <= S_RESTORE;
            irq_active <= 1'b0;
            pc_load    <= 1'b1;
            pc_next    <= ret_pc;
            timeout    <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
`endif
          end
        end
        S_RESTORE: begin
          state  <= S_IDLE;
          irq_id <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef IRQ_SEQ_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer; expected PC loads are queued at stimulus time and popped when pc_load fires.
module tb_irq_sequencer;

  localparam int NIRQ = 32;
  localparam logic [31:0] PC_IRQ = 32'h0000_0800;

  logic            clk = 1'b0;
  logic            rst;
  logic [NIRQ-1:0] irq_pending;
  logic [NIRQ-1:0] irq_mask;
  logic            glob_en;
  logic            insn_boundary;
  logic            retirq;
  logic [31:0]     pc;
  logic [31:0]     pc_irq;
  logic            savepc;
  logic            pc_load;
  logic [31:0]     pc_next;
  logic [NIRQ-1:0] irq_ack;
  logic [4:0]      irq_id;
  logic            irq_active;
  logic            timeout;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ack;
    logic [4:0]  id;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  irq_sequencer #(
    .NIRQ          (NIRQ),
    .VECTORED      (1),
    .VEC_SHIFT     (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_pending  (irq_pending),
    .irq_mask     (irq_mask),
    .glob_en      (glob_en),
    .insn_boundary(insn_boundary),
    .retirq       (retirq),
    .pc           (pc),
    .pc_irq       (pc_irq),
    .savepc       (savepc),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .irq_ack      (irq_ack),
    .irq_id       (irq_id),
    .irq_active   (irq_active),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " savepc"},     savepc,     0);
    check({tag, " pc_load"},    pc_load,    0);
    check({tag, " pc_next"},    pc_next,    0);
    check({tag, " irq_ack"},    irq_ack,    0);
    check({tag, " irq_id"},     irq_id,     0);
    check({tag, " irq_active"}, irq_active, 0);
    check({tag, " timeout"},    timeout,    0);
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] a, input logic [4:0] i);
    exp_t e;
    e.pc  = p;
    e.ack = a;
    e.id  = i;
    sb.push_back(e);
  endtask

  // Wait up to budget cycles for pc_load, then pop and compare against the queue head.
  task automatic expect_load(input string tag, input int budget);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (pc_load === 1'b1) seen = 1'b1;
    end
    check({tag, " pc_load seen"}, seen, 1);
    check({tag, " queue nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (seen) begin
        check({tag, " pc_next"}, pc_next, e.pc);
        check({tag, " irq_ack"}, irq_ack, e.ack);
        check({tag, " irq_id"},  irq_id,  e.id);
      end
    end
  endtask

  // Full entry with exact latency checks: qualifying cycle T is the one after this call drives inputs.
  task automatic enter_irq(input string tag, input logic [31:0] pend, input logic [31:0] msk,
                           input logic [31:0] pcv, input logic [4:0] exp_id);
    irq_pending = pend;
    irq_mask    = msk;
    pc          = pcv;
    push_exp(PC_IRQ + (32'(exp_id) << 2), 32'd1 << exp_id, exp_id);
    push_exp(pcv, 32'd0, exp_id);
    tick();
    check({tag, " savepc@T+1"}, savepc, 1);
    expect_load({tag, " entry@T+2"}, 1);
    irq_pending = '0;
    tick();
    check({tag, " active@T+3"}, irq_active, 1);
    check({tag, " pc_next idle 0"}, pc_next, 0);
  endtask

  task automatic exit_irq(input string tag);
    retirq = 1'b1;
    expect_load({tag, " restore"}, 1);
    retirq = 1'b0;
    check({tag, " inactive after retirq"}, irq_active, 0);
    tick();
  endtask

  initial begin
    int sp_cnt;
    rst           = 1'b1;
    irq_pending   = '0;
    irq_mask      = '1;
    glob_en       = 1'b1;
    insn_boundary = 1'b1;
    retirq        = 1'b0;
    pc            = 32'h0000_0100;
    pc_irq        = PC_IRQ;

    // 1. Reset state; a stray retirq does nothing.
    tick();
    tick();
    check_all_zero("reset");
    rst    = 1'b0;
    retirq = 1'b1;
    tick();
    retirq = 1'b0;
    check("stray retirq pc_load", pc_load, 0);
    tick();
    check("stray retirq pc_load late", pc_load, 0);

    // 2. Single entry/exit on line 2.
    enter_irq("single", 32'h4, 32'hFFFF_FFFF, 32'h100, 5'd2);
`ifndef IRQ_SEQ_TIMEOUT_EN
    for (int i = 0; i < 12; i++) tick();
    check("no watchdog active", irq_active, 1);
    check("no watchdog timeout", timeout, 0);
`endif
    exit_irq("single");
    check("single id cleared", irq_id, 0);

    // 3. Priority and masking.
    enter_irq("masked", 32'h6, 32'hFFFF_FFFD, 32'h200, 5'd2);
    exit_irq("masked");
    enter_irq("prio", 32'h6, 32'hFFFF_FFFF, 32'h204, 5'd1);
    exit_irq("prio");

    glob_en     = 1'b0;
    irq_pending = 32'h4;
    sp_cnt      = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (savepc === 1'b1) sp_cnt++;
    end
    check("glob_en=0 no savepc", sp_cnt, 0);
    glob_en       = 1'b1;
    insn_boundary = 1'b0;
    sp_cnt        = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (savepc === 1'b1) sp_cnt++;
    end
    check("boundary=0 no savepc", sp_cnt, 0);
    irq_pending   = '0;
    insn_boundary = 1'b1;
    tick();

    // 4. New request during ACTIVE is held off, then serviced after restore.
    enter_irq("busy", 32'h4, 32'hFFFF_FFFF, 32'h300, 5'd2);
    irq_pending = 32'h1;
    pc          = 32'h304;
    sp_cnt      = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (savepc === 1'b1 || pc_load === 1'b1) sp_cnt++;
    end
    check("busy no action", sp_cnt, 0);
    check("busy id held", irq_id, 2);
    retirq = 1'b1;
    push_exp(PC_IRQ, 32'h1, 5'd0);
    push_exp(32'h304, 32'd0, 5'd0);
    expect_load("busy restore", 1);
    retirq = 1'b0;
    expect_load("busy reentry", 3);
    irq_pending = '0;
    tick();
    check("reentry active", irq_active, 1);
    exit_irq("reentry");

    // 5. Reset during LOAD aborts; the still-pending line re-enters afterwards.
    irq_pending = 32'h8;
    pc          = 32'h400;
    push_exp(PC_IRQ + 32'hC, 32'h8, 5'd3);
    tick();
    check("abort savepc", savepc, 1);
    expect_load("abort load", 1);
    rst = 1'b1;
    tick();
    check_all_zero("reset in LOAD");
    rst = 1'b0;
    push_exp(PC_IRQ + 32'hC, 32'h8, 5'd3);
    push_exp(32'h400, 32'd0, 5'd3);
    tick();
    check("post-reset savepc", savepc, 1);
    expect_load("post-reset entry", 1);
    irq_pending = '0;
    tick();
    exit_irq("post-reset");

`ifdef IRQ_SEQ_TIMEOUT_EN
    // 6. Watchdog forces a restore 8 cycles after ACTIVE is entered.
    irq_pending = 32'h2;
    pc          = 32'h500;
    push_exp(PC_IRQ + 32'h4, 32'h2, 5'd1);
    push_exp(32'h500, 32'd0, 5'd1);
    tick();
    expect_load("wd entry", 1);
    irq_pending = '0;
    tick();
    sp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (timeout === 1'b1) sp_cnt++;
    end
    check("wd no early timeout", sp_cnt, 0);
    expect_load("wd restore", 1);
    check("wd timeout pulse", timeout, 1);
    tick();
    check("wd timeout cleared", timeout, 0);
`endif

    check("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
